// File: rtl/pipeline_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : pipeline_ctrl
// Description : Hazard and sequencing controller for the IF/ID, ID/EX, EX/MEM
//               and MEM/WB pipeline registers. It produces per-register stall
//               (hold) and flush (bubble) strobes from three sources:
//               load-use hazards, taken branches resolved at the EX/MEM
//               output, and multi-cycle data-memory accesses. A wait-state
//               FSM with a timeout watches the data memory.
//               The optional build macro PIPE_PERF_CNT_EN adds saturating
//               performance counters.
// Ports       : clock, reset (async, active-low)
//               if_id_rs/if_id_rt/if_id_uses_rt : sources of the ID instruction
//               id_ex_mem_read/id_ex_rt         : load in EX and its destination
//               mem_access/dmem_ready           : data-memory handshake
//               mem_pc_src                      : taken branch at EX/MEM output
//               stall_*/flush_*                 : pipeline register strobes
//               mem_error                       : sticky memory timeout flag
//               perf_* (PIPE_PERF_CNT_EN only)  : stall/bubble/flush counters
// Revision    : 1.0 - initial release
// ============================================================================
module pipeline_ctrl #(
    parameter int MEM_TIMEOUT = 16,
    parameter int REG_W       = 5
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [REG_W-1:0] if_id_rs,
    input  logic [REG_W-1:0] if_id_rt,
    input  logic             if_id_uses_rt,
    input  logic             id_ex_mem_read,
    input  logic [REG_W-1:0] id_ex_rt,
    input  logic             mem_access,
    input  logic             dmem_ready,
    input  logic             mem_pc_src,
    output logic             stall_pc,
    output logic             stall_if_id,
    output logic             stall_id_ex,
    output logic             stall_ex_mem,
    output logic             flush_if_id,
    output logic             flush_id_ex,
    output logic             flush_ex_mem,
    output logic             flush_mem_wb,
    output logic             mem_error
`ifdef PIPE_PERF_CNT_EN
    ,
    output logic [31:0]      perf_stall_cycles,
    output logic [31:0]      perf_bubbles,
    output logic [31:0]      perf_flushes
`endif
);

    localparam int c_CNT_W = $clog2(MEM_TIMEOUT) + 1;
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(MEM_TIMEOUT - 1);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE  = c_CNT_W'(1);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        ERROR    = 2'd2
    } state_t;

    state_t             r_state, w_stateNext;
    logic [c_CNT_W-1:0] r_waitCnt, w_waitCntNext;
    logic               r_memError, w_memErrorNext;
    logic               w_memWait;
    logic               w_loadUse;
    logic               w_hold;
    logic               w_branchFlush;
    logic               w_bubble;

    assign w_memWait = mem_access & ~dmem_ready;
    // A load to r0 never creates a real dependency.
    assign w_loadUse = id_ex_mem_read && (id_ex_rt != '0) &&
                       ((id_ex_rt == if_id_rs) || (if_id_uses_rt && (id_ex_rt == if_id_rt)));

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state    <= RUN;
            r_waitCnt  <= '0;
            r_memError <= 1'b0;
        end else begin
            r_state    <= w_stateNext;
            r_waitCnt  <= w_waitCntNext;
            r_memError <= w_memErrorNext;
        end
    end

    always_comb begin
        w_stateNext    = r_state;
        w_waitCntNext  = r_waitCnt;
        w_memErrorNext = r_memError;
        w_hold         = 1'b0;
        w_branchFlush  = 1'b0;
        w_bubble       = 1'b0;
        case (r_state)
            RUN, MEM_WAIT: begin
                if (w_memWait) begin
                    // Memory stall freezes everything up to EX/MEM; a pending
                    // branch stays held and is flushed on the release cycle.
                    w_hold = 1'b1;
                    if (r_state == RUN) begin
                        w_stateNext   = MEM_WAIT;
                        w_waitCntNext = c_CNT_ONE;
                    end else begin
                        w_waitCntNext = r_waitCnt + c_CNT_ONE;
                        if (r_waitCnt == c_CNT_LAST) begin
                            w_stateNext    = ERROR;
                            w_memErrorNext = 1'b1;
                        end
                    end
                end else begin
                    // Release cycle (or ordinary RUN cycle). A dropped
                    // mem_access without ready is also treated as release.
                    w_stateNext   = RUN;
                    w_waitCntNext = '0;
                    if (mem_pc_src) begin
                        // Squashing the younger instructions removes any
                        // load-use hazard among them.
                        w_branchFlush = 1'b1;
                    end else if (w_loadUse) begin
                        w_bubble = 1'b1;
                    end
                end
            end
            ERROR: begin
                w_hold = 1'b1;
            end
            default: begin
                w_stateNext = RUN;
            end
        endcase
    end

    // The strobes are forced low while reset is held, independent of inputs.
    assign stall_pc     = reset & (w_hold | w_bubble);
    assign stall_if_id  = reset & (w_hold | w_bubble);
    assign stall_id_ex  = reset & w_hold;
    assign stall_ex_mem = reset & w_hold;
    assign flush_if_id  = reset & w_branchFlush;
    assign flush_id_ex  = reset & (w_branchFlush | w_bubble);
    assign flush_ex_mem = reset & w_branchFlush;
    assign flush_mem_wb = reset & w_hold;
    assign mem_error    = r_memError;

`ifdef PIPE_PERF_CNT_EN
    logic [31:0] r_perfStall, r_perfBubble, r_perfFlush;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_perfStall  <= '0;
            r_perfBubble <= '0;
            r_perfFlush  <= '0;
        end else begin
            if (w_hold && (r_perfStall != '1))
                r_perfStall <= r_perfStall + 32'd1;
            if (w_bubble && (r_perfBubble != '1))
                r_perfBubble <= r_perfBubble + 32'd1;
            if (w_branchFlush && (r_perfFlush != '1))
                r_perfFlush <= r_perfFlush + 32'd1;
        end
    end

    assign perf_stall_cycles = r_perfStall;
    assign perf_bubbles      = r_perfBubble;
    assign perf_flushes      = r_perfFlush;
`endif

endmodule
`default_nettype wire

// File: tb/tb_pipeline_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_pipeline_ctrl
// Description : Self-checking bench for pipeline_ctrl (MEM_TIMEOUT = 4).
//               Each driven cycle pushes the reference model's expected
//               strobe vector to a scoreboard queue; the scenario task pops
//               and compares it mid-cycle. Define PIPE_PERF_CNT_EN for the
//               counter build.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pipeline_ctrl;

    localparam int c_TIMEOUT = 4;

    // {stall_pc, stall_if_id, stall_id_ex, stall_ex_mem,
    //  flush_if_id, flush_id_ex, flush_ex_mem, flush_mem_wb, mem_error}
    localparam logic [8:0] c_HOLD   = 9'b1111_0001_0;
    localparam logic [8:0] c_BRANCH = 9'b0000_1110_0;
    localparam logic [8:0] c_BUBBLE = 9'b1100_0100_0;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic [4:0] if_id_rs = '0, if_id_rt = '0, id_ex_rt = '0;
    logic       if_id_uses_rt = 1'b0, id_ex_mem_read = 1'b0;
    logic       mem_access = 1'b0, dmem_ready = 1'b0, mem_pc_src = 1'b0;
    logic       stall_pc, stall_if_id, stall_id_ex, stall_ex_mem;
    logic       flush_if_id, flush_id_ex, flush_ex_mem, flush_mem_wb, mem_error;
    logic [8:0] w_obs;
`ifdef PIPE_PERF_CNT_EN
    logic [31:0] perf_stall_cycles, perf_bubbles, perf_flushes;
`endif

    int checks = 0;
    int errors = 0;
    logic [8:0] sb[$];

    // Reference model state
    int          mState = 0;   // 0 run, 1 waiting, 2 error
    int          mWaits = 0;   // wait cycles seen for the current access
    logic        mErr   = 1'b0;
    int unsigned mStall = 0, mBub = 0, mFl = 0;

    pipeline_ctrl #(.MEM_TIMEOUT(c_TIMEOUT), .REG_W(5)) dut (
        .clock          (clock),
        .reset          (reset),
        .if_id_rs       (if_id_rs),
        .if_id_rt       (if_id_rt),
        .if_id_uses_rt  (if_id_uses_rt),
        .id_ex_mem_read (id_ex_mem_read),
        .id_ex_rt       (id_ex_rt),
        .mem_access     (mem_access),
        .dmem_ready     (dmem_ready),
        .mem_pc_src     (mem_pc_src),
        .stall_pc       (stall_pc),
        .stall_if_id    (stall_if_id),
        .stall_id_ex    (stall_id_ex),
        .stall_ex_mem   (stall_ex_mem),
        .flush_if_id    (flush_if_id),
        .flush_id_ex    (flush_id_ex),
        .flush_ex_mem   (flush_ex_mem),
        .flush_mem_wb   (flush_mem_wb),
        .mem_error      (mem_error)
`ifdef PIPE_PERF_CNT_EN
        ,
        .perf_stall_cycles (perf_stall_cycles),
        .perf_bubbles      (perf_bubbles),
        .perf_flushes      (perf_flushes)
`endif
    );

    assign w_obs = {stall_pc, stall_if_id, stall_id_ex, stall_ex_mem,
                    flush_if_id, flush_id_ex, flush_ex_mem, flush_mem_wb, mem_error};

    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    function automatic logic [8:0] expOut();
        logic [8:0] e;
        logic       hazard;
        e = '0;
        if (!reset) return '0;
        hazard = id_ex_mem_read && (id_ex_rt != 0) &&
                 (id_ex_rt == if_id_rs || (if_id_uses_rt && id_ex_rt == if_id_rt));
        if (mState == 2 || (mem_access && !dmem_ready)) e = c_HOLD;
        else if (mem_pc_src)                           e = c_BRANCH;
        else if (hazard)                               e = c_BUBBLE;
        e[0] = mErr;
        return e;
    endfunction

    always @(posedge clock or negedge reset) begin
        logic [8:0] e;
        if (!reset) begin
            mState <= 0; mWaits <= 0; mErr <= 1'b0;
            mStall <= 0; mBub <= 0; mFl <= 0;
        end else begin
            e = expOut();
            if (e[5]) mStall <= mStall + 1;
            if (e[8] && !e[5]) mBub <= mBub + 1;
            if (e[4]) mFl <= mFl + 1;
            if (mState == 0 && mem_access && !dmem_ready) begin
                mState <= 1; mWaits <= 1;
            end else if (mState == 1) begin
                if (mem_access && !dmem_ready) begin
                    mWaits <= mWaits + 1;
                    if (mWaits + 1 >= c_TIMEOUT) begin
                        mState <= 2; mErr <= 1'b1;
                    end
                end else begin
                    mState <= 0; mWaits <= 0;
                end
            end
        end
    end

    // Drives one cycle of inputs and records the model's expectation.
    task automatic drive(input logic ma, input logic dr, input logic pc, input logic mr,
                         input logic [4:0] ert, input logic [4:0] rs, input logic [4:0] rt,
                         input logic urt);
        mem_access = ma; dmem_ready = dr; mem_pc_src = pc; id_ex_mem_read = mr;
        id_ex_rt = ert; if_id_rs = rs; if_id_rt = rt; if_id_uses_rt = urt;
        sb.push_back(expOut());
    endtask

    task automatic test_reset();
        logic [8:0] want;
        reset = 1'b0;
        #1;
        drive(1'b0, 1'b1, 1'b1, 1'b1, 5'd5, 5'd5, 5'd0, 1'b0);
        @(negedge clock);
        want = sb.pop_front();
        checks++;
        if (w_obs !== want || w_obs !== 9'd0) begin
            errors++; $display("FAIL reset_outputs got=%b want=%b", w_obs, 9'd0);
        end
`ifdef PIPE_PERF_CNT_EN
        checks++;
        if (perf_stall_cycles !== 0 || perf_bubbles !== 0 || perf_flushes !== 0) begin
            errors++; $display("FAIL reset_perf got=%0d/%0d/%0d want=0/0/0",
                               perf_stall_cycles, perf_bubbles, perf_flushes);
        end
`endif
        @(posedge clock); #1;
        reset = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
        @(negedge clock);
        want = sb.pop_front();
        checks++;
        if (w_obs !== want) begin
            errors++; $display("FAIL reset_idle got=%b want=%b", w_obs, want);
        end
        @(posedge clock); #1;
    endtask

    task automatic test_load_use();
        logic [8:0] want;
        for (int i = 0; i < 2; i++) begin
            if (i == 0) drive(1'b0, 1'b0, 1'b0, 1'b1, 5'd5, 5'd5, 5'd9, 1'b0);
            else        drive(1'b0, 1'b0, 1'b0, 1'b0, 5'd5, 5'd3, 5'd9, 1'b0);
            @(negedge clock);
            want = sb.pop_front();
            checks++;
            if (w_obs !== want || w_obs !== (i == 0 ? c_BUBBLE : 9'd0)) begin
                errors++; $display("FAIL load_use[%0d] got=%b want=%b", i, w_obs, want);
            end
            @(posedge clock); #1;
        end
    endtask

    task automatic test_no_hazard();
        logic [8:0] want;
        for (int i = 0; i < 3; i++) begin
            case (i)
                0: drive(1'b0, 1'b0, 1'b0, 1'b1, 5'd0, 5'd0, 5'd0, 1'b1); // load to r0
                1: drive(1'b0, 1'b0, 1'b0, 1'b1, 5'd7, 5'd2, 5'd7, 1'b0); // rt not a source
                default: drive(1'b0, 1'b0, 1'b0, 1'b0, 5'd7, 5'd7, 5'd7, 1'b1); // not a load
            endcase
            @(negedge clock);
            want = sb.pop_front();
            checks++;
            if (w_obs !== want || w_obs !== 9'd0) begin
                errors++; $display("FAIL no_hazard[%0d] got=%b want=%b", i, w_obs, want);
            end
            @(posedge clock); #1;
        end
    endtask

    task automatic test_mem_wait();
        logic [8:0] want;
        for (int i = 0; i < 5; i++) begin
            if (i < 3)       drive(1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
            else if (i == 3) drive(1'b1, 1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
            else             drive(1'b0, 1'b0, 1'b0, 1'b1, 5'd4, 5'd4, 5'd0, 1'b0);
            @(negedge clock);
            want = sb.pop_front();
            checks++;
            if (w_obs !== want || w_obs !== (i < 3 ? c_HOLD : (i == 4 ? c_BUBBLE : 9'd0))) begin
                errors++; $display("FAIL mem_wait[%0d] got=%b want=%b", i, w_obs, want);
            end
            @(posedge clock); #1;
        end
    endtask

    task automatic test_branch();
        logic [8:0] want;
        drive(1'b0, 1'b0, 1'b1, 1'b1, 5'd6, 5'd6, 5'd6, 1'b1);
        @(negedge clock);
        want = sb.pop_front();
        checks++;
        if (w_obs !== want || w_obs !== c_BRANCH) begin
            errors++; $display("FAIL branch_over_loaduse got=%b want=%b", w_obs, want);
        end
        @(posedge clock); #1;
`ifdef PIPE_PERF_CNT_EN
        // Load-use bubbles: 2 (one from test_load_use, one after test_mem_wait)
        checks++;
        if (perf_bubbles !== 32'd2 || perf_stall_cycles !== 32'd3 || perf_flushes !== 32'd1) begin
            errors++; $display("FAIL perf_counts got=%0d/%0d/%0d want=2/3/1",
                               perf_bubbles, perf_stall_cycles, perf_flushes);
        end
`endif
    endtask

    task automatic test_back_to_back();
        logic [8:0] want;
        for (int i = 0; i < 4; i++) begin
            case (i)
                0, 1: drive(1'b1, 1'b0, 1'b1, 1'b1, 5'd3, 5'd3, 5'd0, 1'b0); // stall beats branch
                2:    drive(1'b1, 1'b1, 1'b1, 1'b1, 5'd3, 5'd3, 5'd0, 1'b0); // release flushes
                default: drive(1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
            endcase
            @(negedge clock);
            want = sb.pop_front();
            checks++;
            if (w_obs !== want || w_obs !== (i < 2 ? c_HOLD : (i == 2 ? c_BRANCH : 9'd0))) begin
                errors++; $display("FAIL back_to_back[%0d] got=%b want=%b", i, w_obs, want);
            end
            @(posedge clock); #1;
        end
    endtask

    task automatic test_protocol_drop();
        logic [8:0] want;
        for (int i = 0; i < 3; i++) begin
            if (i < 2) drive(1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
            else       drive(1'b0, 1'b0, 1'b0, 1'b1, 5'd8, 5'd1, 5'd8, 1'b1);
            @(negedge clock);
            want = sb.pop_front();
            checks++;
            if (w_obs !== want || w_obs !== (i < 2 ? c_HOLD : c_BUBBLE)) begin
                errors++; $display("FAIL protocol_drop[%0d] got=%b want=%b", i, w_obs, want);
            end
            @(posedge clock); #1;
        end
`ifdef PIPE_PERF_CNT_EN
        checks++;
        if (perf_stall_cycles !== mStall || perf_bubbles !== mBub || perf_flushes !== mFl) begin
            errors++; $display("FAIL perf_model got=%0d/%0d/%0d want=%0d/%0d/%0d",
                               perf_stall_cycles, perf_bubbles, perf_flushes, mStall, mBub, mFl);
        end
`endif
    endtask

    task automatic test_reset_mid_wait();
        logic [8:0] want;
        drive(1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
        @(negedge clock); void'(sb.pop_front());
        @(posedge clock); #1;
        drive(1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
        @(negedge clock); void'(sb.pop_front());
        #2 reset = 1'b0;
        #1;
        checks++;
        if (w_obs !== 9'd0) begin
            errors++; $display("FAIL reset_mid_wait got=%b want=%b", w_obs, 9'd0);
        end
        @(posedge clock); #1;
        reset = 1'b1;
        // Back in RUN: a load-use hazard must produce a bubble, not a hold.
        drive(1'b0, 1'b0, 1'b0, 1'b1, 5'd2, 5'd2, 5'd0, 1'b0);
        @(negedge clock);
        want = sb.pop_front();
        checks++;
        if (w_obs !== want || w_obs !== c_BUBBLE) begin
            errors++; $display("FAIL after_reset_run got=%b want=%b", w_obs, want);
        end
        @(posedge clock); #1;
    endtask

    task automatic test_timeout();
        logic [8:0] want;
        for (int i = 0; i < 7; i++) begin
            if (i < 6) drive(1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
            else       drive(1'b0, 1'b1, 1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
            @(negedge clock);
            want = sb.pop_front();
            checks++;
            if (w_obs !== want || w_obs !== (i < 4 ? c_HOLD : (c_HOLD | 9'd1))) begin
                errors++; $display("FAIL timeout[%0d] got=%b want=%b", i, w_obs, want);
            end
            @(posedge clock); #1;
        end
        reset = 1'b0;
        #1;
        checks++;
        if (w_obs !== 9'd0) begin
            errors++; $display("FAIL error_reset got=%b want=%b", w_obs, 9'd0);
        end
        @(posedge clock); #1;
        reset = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
        @(negedge clock);
        want = sb.pop_front();
        checks++;
        if (w_obs !== want || w_obs !== 9'd0) begin
            errors++; $display("FAIL error_release got=%b want=%b", w_obs, want);
        end
        @(posedge clock); #1;
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_no_hazard();
        test_mem_wait();
        test_branch();
        test_back_to_back();
        test_protocol_drop();
        test_reset_mid_wait();
        test_timeout();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
